fan_result_collector: RTL and testbench

Downstream stage of `fan_tree` in the unstructured-sparsity datapath. Captures one cycle's set of FAN output lanes (`out_valid` / `out`), which are sparse and scattered across the adder-output positions. Drains the valid lanes one per cycle, lowest index first, onto a single valid/ready result stream. Each result is tagged with its lane index and a per-snapshot sequence number so the writeback stage can map sums back to output rows.

---
 rtl/fan_result_collector.sv | 102 ++++++++++
 tb/tb_fan_result_collector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fan_result_collector.sv
// Collects one snapshot of sparse FAN output lanes and drains the valid ones,
// lowest index first, as a tagged valid/ready result stream.
module fan_result_collector #(
  parameter int DW_DATA = 8,
  parameter int N       = 32,
  parameter int LW      = 6,
  parameter int SEQ_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*(N-1)-1:0]          in_out_valid,
  input  logic [DW_DATA*2*(N-1)-1:0]  in_out,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DW_DATA-1:0]          res_data,
  output logic [LW-1:0]               res_lane,
  output logic                        res_last,
  output logic [SEQ_W-1:0]            res_tag,
  output logic                        empty_snap,
  output logic                        busy
);

  localparam int L = 2 * (N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                   state_r;
  logic [L-1:0]             mask_r;
  logic [DW_DATA*L-1:0]     snap_r;
  logic [SEQ_W-1:0]         seq_r;
  logic [SEQ_W-1:0]         tag_r;
  logic                     empty_r;

  logic                     drain_s;
  logic [L-1:0]             low_bit_s;
  logic [LW-1:0]            lane_s;
  logic [DW_DATA-1:0]       data_s;
  logic                     last_s;
  logic                     xfer_s;
  logic                     ready_s;
  logic                     accept_s;

  assign drain_s   = (state_r == DRAIN);
  // Two's-complement trick isolates the lowest set bit of the pending mask.
  assign low_bit_s = mask_r & (~mask_r + {{(L-1){1'b0}}, 1'b1});
  assign last_s    = drain_s && ((mask_r & (mask_r - {{(L-1){1'b0}}, 1'b1})) == {L{1'b0}});
  assign xfer_s    = drain_s && res_ready;
  assign ready_s   = !drain_s || (xfer_s && last_s);
  assign accept_s  = in_valid && ready_s;

  // One-hot mux: lane index and lane data of the lowest pending lane.
  always_comb begin
    lane_s = {LW{1'b0}};
    data_s = {DW_DATA{1'b0}};
    for (int k = 0; k < L; k++) begin
      lane_s = lane_s | ({LW{low_bit_s[k]}} & LW'(k));
      data_s = data_s | ({DW_DATA{low_bit_s[k]}} & snap_r[DW_DATA*k +: DW_DATA]);
    end
  end

  // Snapshot capture, drain sequencing, sequence numbering and empty pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mask_r  <= {L{1'b0}};
      snap_r  <= {(DW_DATA*L){1'b0}};
      seq_r   <= {SEQ_W{1'b0}};
      tag_r   <= {SEQ_W{1'b0}};
      empty_r <= 1'b0;
    end else begin
      if (accept_s) begin
        mask_r  <= in_out_valid;
        snap_r  <= in_out;
        tag_r   <= seq_r;
        seq_r   <= seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
        empty_r <= (in_out_valid == {L{1'b0}});
        state_r <= (in_out_valid != {L{1'b0}}) ? DRAIN : IDLE;
      end else if (xfer_s) begin
        mask_r  <= mask_r & ~low_bit_s;
        empty_r <= 1'b0;
        state_r <= last_s ? IDLE : DRAIN;
      end else begin
        empty_r <= 1'b0;
      end
    end
  end

  assign in_ready   = ready_s;
  assign res_valid  = drain_s;
  assign res_data   = data_s;
  assign res_lane   = lane_s;
  assign res_last   = last_s;
  assign res_tag    = tag_r;
  assign empty_snap = empty_r;
  assign busy       = drain_s;

endmodule

// File: tb/tb_fan_result_collector.sv
// Directed, table-driven bench for fan_result_collector with hand-written
// sequences for full-width drain, mid-drain reset and tag wrap.
module tb_fan_result_collector;

  localparam int DW = 8;
  localparam int N  = 32;
  localparam int L  = 2 * (N - 1);
  localparam int LW = 6;
  localparam int SW = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [L-1:0]      in_out_valid;
  logic [DW*L-1:0]   in_out;
  logic              res_valid;
  logic              res_ready;
  logic [DW-1:0]     res_data;
  logic [LW-1:0]     res_lane;
  logic              res_last;
  logic [SW-1:0]     res_tag;
  logic              empty_snap;
  logic              busy;

  fan_result_collector #(.DW_DATA(DW), .N(N), .LW(LW), .SEQ_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_out_valid(in_out_valid), .in_out(in_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_lane(res_lane),
    .res_last(res_last), .res_tag(res_tag), .empty_snap(empty_snap), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [L-1:0] m;
    int           ds;
    logic         rr;
    logic         ir;
    logic         rv;
    logic [5:0]   lane;
    logic [7:0]   data;
    logic         last;
    logic [7:0]   tag;
    logic         empty;
  } vec_t;

  vec_t          tbl[$];
  logic [DW*L-1:0] dv[5];
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic iv, input logic [L-1:0] m, input int ds, input logic rr,
                     input logic ir, input logic rv, input logic [5:0] lane,
                     input logic [7:0] data, input logic last, input logic [7:0] tag,
                     input logic empty);
    vec_t v;
    v.iv = iv; v.m = m; v.ds = ds; v.rr = rr; v.ir = ir; v.rv = rv;
    v.lane = lane; v.data = data; v.last = last; v.tag = tag; v.empty = empty;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [L-1:0] M1 = 62'h2000000000000021;
  localparam logic [L-1:0] MA = 62'h0000000000000006;
  localparam logic [L-1:0] MB = 62'h1000000000000000;
  localparam logic [L-1:0] Z  = 62'h0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_out_valid = '0; in_out = '0;
    // Data vectors: lanes without a valid bit carry junk that must never appear.
    for (int d = 0; d < 5; d++) dv[d] = '0;
    dv[0][0*8 +: 8] = 8'h10; dv[0][5*8 +: 8] = 8'h55; dv[0][61*8 +: 8] = 8'hF0;
    dv[0][3*8 +: 8] = 8'h77;
    for (int k = 0; k < L; k++) dv[1][k*8 +: 8] = 8'hFF;
    for (int k = 0; k < L; k++) dv[2][k*8 +: 8] = 8'(k);
    dv[3][1*8 +: 8] = 8'hA1; dv[3][2*8 +: 8] = 8'hA2; dv[3][60*8 +: 8] = 8'hEE;
    dv[4][1*8 +: 8] = 8'h33; dv[4][2*8 +: 8] = 8'h33; dv[4][60*8 +: 8] = 8'hB0;

    //   iv  mask ds rr   ir   rv   lane   data   last tag   empty
    add(1'b1, M1, 0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd0, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b0, 1'b1, 6'd0,  8'h10, 1'b0, 8'd0, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b0, 1'b1, 6'd5,  8'h55, 1'b0, 8'd0, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b1, 1'b1, 6'd61, 8'hF0, 1'b1, 8'd0, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd0, 1'b0);
    // Backpressure: lane 0 held for five cycles.
    add(1'b1, M1, 0, 1'b0, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0, Z, 0, 1'b0, 1'b0, 1'b1, 6'd0, 8'h10, 1'b0, 8'd1, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b0, 1'b1, 6'd0,  8'h10, 1'b0, 8'd1, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b0, 1'b1, 6'd5,  8'h55, 1'b0, 8'd1, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b1, 1'b1, 6'd61, 8'hF0, 1'b1, 8'd1, 1'b0);
    // Empty snapshot with all-ones data.
    add(1'b1, Z,  1, 1'b1, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd1, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd2, 1'b1);
    add(1'b0, Z,  0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd2, 1'b0);
    // Back-to-back A={1,2}, B={60} with in_valid held.
    add(1'b1, MA, 3, 1'b1, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd2, 1'b0);
    add(1'b1, MB, 4, 1'b1, 1'b0, 1'b1, 6'd1,  8'hA1, 1'b0, 8'd3, 1'b0);
    add(1'b1, MB, 4, 1'b1, 1'b1, 1'b1, 6'd2,  8'hA2, 1'b1, 8'd3, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b1, 1'b1, 6'd60, 8'hB0, 1'b1, 8'd4, 1'b0);
    add(1'b0, Z,  0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'd4, 1'b0);

    do_reset();
    #1;
    chk("rst_res_data", 64'(res_data), 64'h0);
    chk("rst_res_lane", 64'(res_lane), 64'h0);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_out_valid = tbl[i].m; in_out = dv[tbl[i].ds];
      res_ready = tbl[i].rr;
      #1;
      chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
      chk($sformatf("row%0d_res_valid", i), 64'(res_valid), 64'(tbl[i].rv));
      chk($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].rv));
      chk($sformatf("row%0d_res_last", i), 64'(res_last), 64'(tbl[i].last));
      chk($sformatf("row%0d_res_tag", i), 64'(res_tag), 64'(tbl[i].tag));
      chk($sformatf("row%0d_empty_snap", i), 64'(empty_snap), 64'(tbl[i].empty));
      if (tbl[i].rv) begin
        chk($sformatf("row%0d_res_lane", i), 64'(res_lane), 64'(tbl[i].lane));
        chk($sformatf("row%0d_res_data", i), 64'(res_data), 64'(tbl[i].data));
      end
    end

    // Full-width snapshot, data equals lane index.
    do_reset();
    in_valid = 1'b1; in_out_valid = {L{1'b1}}; in_out = dv[2]; res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < L; k++) begin
      #1;
      chk($sformatf("full_valid_%0d", k), 64'(res_valid), 64'h1);
      chk($sformatf("full_lane_%0d", k), 64'(res_lane), 64'(k));
      chk($sformatf("full_data_%0d", k), 64'(res_data), 64'(k));
      chk($sformatf("full_last_%0d", k), 64'(res_last), 64'(k == L - 1));
      chk($sformatf("full_tag_%0d", k), 64'(res_tag), 64'h0);
      @(negedge clk);
    end
    #1;
    chk("full_done_valid", 64'(res_valid), 64'h0);

    // Second full snapshot, reset asserted after lane 20 transfers.
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k <= 20; k++) @(negedge clk);
    #1;
    chk("pre_rst_lane", 64'(res_lane), 64'd21);
    chk("pre_rst_tag", 64'(res_tag), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'h1);
    chk("mid_rst_tag", 64'(res_tag), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 257 single-lane snapshots: tag runs 0..255 then wraps to 0.
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_out_valid = '0; in_out_valid[i % L] = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("wrap_valid_%0d", i), 64'(res_valid), 64'h1);
      chk($sformatf("wrap_lane_%0d", i), 64'(res_lane), 64'(i % L));
      chk($sformatf("wrap_data_%0d", i), 64'(res_data), 64'(i % L));
      chk($sformatf("wrap_last_%0d", i), 64'(res_last), 64'h1);
      chk($sformatf("wrap_tag_%0d", i), 64'(res_tag), 64'(i % 256));
    end
    @(negedge clk);
    #1;
    chk("wrap_done_valid", 64'(res_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
